// File: rtl/capture_buffer.sv
// capture_buffer: captures a DEPTH-sample window around the trigger into RAM and streams it out over valid/ready.
// CAPTURE_PRETRIG_EN builds the programmable pre-trigger window; without it the window starts at the trigger.
module capture_buffer #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk_PLL,
  input  logic              reset,
  input  logic              arm,
  input  logic [ADDR_W-1:0] preTrig,
  input  logic              triggerIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              trigClear,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  input  logic              rdReady,
  output logic              rdLast
);
  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READOUT} state_t;
  localparam logic [ADDR_W-1:0] ONE = 1;
  state_t state_q, state_d, first_state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] pre_trig, wr_ptr_q, wr_ptr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] pf_data_q, out_data_q, out_data_d;
  logic pf_vld_q, pf_vld_d, pf_last_q, pf_last_d, out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic iss_done_q, iss_done_d, trig_clear_q, trig_clear_d, done_q, done_d;
  logic accept, trig, we, wait_we, prefill_end, fire, out_load, issue;
`ifdef CAPTURE_PRETRIG_EN
  logic [ADDR_W-1:0] pre_trig_q, pre_trig_d;
  always_comb pre_trig_d = accept ? preTrig : pre_trig_q;
  always_ff @(posedge clk_PLL) pre_trig_q <= reset ? '0 : pre_trig_d;
  assign pre_trig    = pre_trig_q;
  assign wait_we     = 1'b1;
  assign first_state = preTrig == '0 ? WAIT_TRIG : PREFILL;
  assign prefill_end = wr_ptr_q == pre_trig_q - ONE;
`else
  logic unused_pre_trig;
  assign unused_pre_trig = ^preTrig;
  assign pre_trig    = '0;
  // nothing ahead of the trigger is kept, so the trigger sample lands at address 0
  assign wait_we     = triggerIn;
  assign first_state = WAIT_TRIG;
  assign prefill_end = 1'b0;
`endif
  always_ff @(posedge clk_PLL) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = arm ? first_state : IDLE;
      PREFILL:   state_d = prefill_end ? WAIT_TRIG : PREFILL;
      WAIT_TRIG: state_d = !triggerIn ? WAIT_TRIG : pre_trig == '1 ? READOUT : POST;
      POST:      state_d = post_cnt_q == ONE ? READOUT : POST;
      READOUT:   state_d = fire && out_last_q ? IDLE : READOUT;
      default:   state_d = IDLE;
    endcase
  end
  // readout is a RAM-output prefetch stage feeding the output register; a read issues only when its slot frees up
  always_comb begin
    accept       = state_q == IDLE && arm;
    trig         = state_q == WAIT_TRIG && triggerIn;
    we           = state_q == PREFILL || state_q == POST || (state_q == WAIT_TRIG && wait_we);
    fire         = out_vld_q && rdReady;
    out_load     = pf_vld_q && (!out_vld_q || rdReady);
    issue        = state_q == READOUT && !iss_done_q && (!pf_vld_q || out_load);
    wr_ptr_d     = accept ? '0 : we ? wr_ptr_q + ONE : wr_ptr_q;
    rd_addr_d    = accept ? '0 : trig ? wr_ptr_q - pre_trig : issue ? rd_addr_q + ONE : rd_addr_q;
    post_cnt_d   = accept ? '0 : trig ? ~pre_trig : state_q == POST ? post_cnt_q - ONE : post_cnt_q;
    rd_cnt_d     = accept ? '0 : issue ? rd_cnt_q + ONE : rd_cnt_q;
    iss_done_d   = !accept && (iss_done_q || (issue && &rd_cnt_q));
    pf_vld_d     = issue || (pf_vld_q && !out_load);
    pf_last_d    = issue ? &rd_cnt_q : pf_last_q;
    out_vld_d    = out_load || (out_vld_q && !fire);
    out_data_d   = out_load ? pf_data_q : out_data_q;
    out_last_d   = out_load ? pf_last_q : out_last_q;
    trig_clear_d = accept;
    done_d       = fire && out_last_q;
  end
  always_ff @(posedge clk_PLL) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_addr_q    <= '0;
      post_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      iss_done_q   <= 1'b0;
      pf_vld_q     <= 1'b0;
      pf_last_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      trig_clear_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_addr_q    <= rd_addr_d;
      post_cnt_q   <= post_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      iss_done_q   <= iss_done_d;
      pf_vld_q     <= pf_vld_d;
      pf_last_q    <= pf_last_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      trig_clear_q <= trig_clear_d;
      done_q       <= done_d;
    end
  end
  always_ff @(posedge clk_PLL) begin
    if (we) mem[wr_ptr_q] <= dataIn;
    if (issue) pf_data_q <= mem[rd_addr_q];
  end
  always_comb begin
    busy      = state_q != IDLE;
    trigClear = trig_clear_q;
    done      = done_q;
    rdData    = out_data_q;
    rdValid   = out_vld_q;
    rdLast    = out_last_q;
  end
endmodule

// File: doc/capture_buffer.md
# capture_buffer

Sample-capture controller downstream of the trigger block: consumes the registered sample stream and the sticky trigger flag, stores a fixed window of `DEPTH` samples in on-chip RAM, then streams the window to the host-link side over a valid/ready interface. The window holds a programmable number of pre-trigger samples. The controller clears the trigger block on every new capture.

## Interface
- `DATA_W`, 3: sample width (channels).
- `ADDR_W`, 8: RAM address width. DEPTH = 2^ADDR_W samples per capture.
- `clk_PLL` in 1: sampling clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: start-capture request, sampled each cycle.
- `preTrig` in ADDR_W: pre-trigger sample count, 0..DEPTH-1. Latched on accepted `arm`.
- `triggerIn` in 1: sticky trigger flag from the trigger block.
- `dataIn` in DATA_W: registered samples from the trigger block, aligned with `triggerIn`.
- `trigClear` out 1: one-cycle pulse that resets the trigger block.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final readout transfer.
- `rdData` out DATA_W: readout sample.
- `rdValid` out 1: `rdData` is valid.
- `rdReady` in 1: consumer accepts the sample.
- `rdLast` out 1: marks the final sample of the window, qualified by `rdValid`.

## Operation
States are IDLE, PREFILL, WAIT_TRIG, POST and READOUT.

- **IDLE**
  - Outputs are 0.
  - `arm`=1 is accepted: latch `preTrig`, clear `wrPtr` and the counters, pulse `trigClear`.
  - Next state is PREFILL, or WAIT_TRIG when `preTrig`=0.
- **PREFILL**
  - Each cycle: write `dataIn` to RAM[`wrPtr`], `wrPtr`++, `fillCnt`++.
  - `triggerIn` is ignored.
  - Go to WAIT_TRIG on the cycle that writes sample number `preTrig`.
- **WAIT_TRIG**
  - Writes continue circularly; `wrPtr` wraps DEPTH-1 → 0.
  - On the first cycle with `triggerIn`=1, the sample written that cycle is the trigger sample.
  - Latch `startAddr` = `wrPtr` − `preTrig` (mod DEPTH) and `postCnt` = DEPTH − `preTrig` − 1.
  - If `postCnt`=0, go to READOUT; otherwise go to POST.
- **POST**
  - Write each cycle and decrement `postCnt`.
  - Go to READOUT when the write that takes `postCnt` to 0 occurs.
  - Total samples written since the trigger = DEPTH − `preTrig`, trigger sample included.
- **READOUT**
  - `rdAddr` starts at `startAddr` and increments mod DEPTH per handshake; DEPTH words in total.
  - The trigger sample is word index `preTrig`.
  - `rdLast`=1 on word DEPTH−1.
  - After its handshake: IDLE, `done`=1 for one cycle.
- **Arithmetic:** all pointer and count arithmetic is ADDR_W-bit modulo DEPTH. Counters never exceed DEPTH.
- **Boundary conditions**
  - `arm` while `busy`=1: ignored, no `trigClear`.
  - `triggerIn` already high on the first WAIT_TRIG cycle: that cycle triggers.
  - `preTrig`=DEPTH−1: `postCnt`=0, so READOUT follows the trigger cycle directly.
  - `reset` in any state: IDLE next cycle; all outputs, pointers and counters go to 0. RAM contents are not cleared.
  - `reset` and `arm` in the same cycle: `reset` wins.

## Timing
- **Arm:** `arm` accepted at edge N → `trigClear`=1 and `busy`=1 during cycle N+1. The first write (PREFILL or WAIT_TRIG) is at edge N+1.
- **Trigger:** `triggerIn` high at edge T in WAIT_TRIG → `dataIn` at edge T is the trigger sample. The last post-trigger write is at edge T + DEPTH − 1 − `preTrig`.
- **Readout start:** RAM has 1-cycle read latency. First `rdValid`=1 is 2 cycles after the last write.
- **Handshake:** a transfer occurs on an edge where `rdValid`=1 and `rdReady`=1.
  - While `rdValid`=1 and `rdReady`=0, `rdData` and `rdLast` are held stable.
  - `rdValid` is not deasserted until the transfer.
  - With `rdReady` held high, throughput is 1 word per cycle; a prefetch register hides RAM latency.
- **Done:** `done` pulses the cycle after the `rdLast` transfer. `busy` drops in that same cycle.

## Configuration
- `CAPTURE_PRETRIG_EN` defined:
  - Full behaviour above.
- `CAPTURE_PRETRIG_EN` undefined:
  - `preTrig` is ignored and treated as 0; PREFILL is not built.
  - No RAM writes in WAIT_TRIG until the trigger.
  - The trigger sample is written to address 0, `startAddr`=0, and the window holds DEPTH post-trigger samples.

## Test plan
All scenarios use ADDR_W=4 (DEPTH=16), DATA_W=3, `CAPTURE_PRETRIG_EN` defined unless stated.

- **Pre-trigger alignment:** `preTrig`=4, `dataIn`=counter mod 8, `triggerIn` at the 10th sample after arm, `rdReady`=1 → 16 words read. Word 4 equals the trigger-cycle value; words are consecutive mod 8; `rdLast` only on word 15; `done` one cycle later.
- **Immediate readout:** `preTrig`=15 → READOUT entered right after the trigger cycle. The trigger sample is word 15.
- **Backpressure:** `rdReady` toggled with a 0,0,1 pattern → `rdData` is held stable while stalled; exactly 16 transfers, no duplicates or drops.
- **Arm handling:** `triggerIn` already high when arm is accepted → `trigClear` pulses at N+1. With `preTrig`=0, the trigger is recognised on the first WAIT_TRIG cycle. A second `arm` while busy produces no `trigClear`.
- **Reset mid-operation:** `reset` asserted mid-POST → next cycle state is IDLE with `busy`, `rdValid`, `done` = 0. A fresh arm then captures correctly.
- **Macro undefined:** `preTrig`=4 is ignored. Word 0 is the trigger sample and 16 post-trigger samples are read.
